fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised hazard and forwarding scoreboard for the pipelined core. It generalises the fixed E/M/W tag comparators to DEPTH post-decode stages and SRCS source operands.
- It tracks destination tags of in-flight instructions in a shift register. It raises a decode stall on load-use hazards and produces registered per-source forward selects that are valid while the consumer is in Execute.
- It sits beside the datapath: fed by decode, and it drives the bypass muxes and the StallF/StallD/FlushE controls.

Parameters:
- NREG, 16, architectural register count. AW = $clog2(NREG).
- DEPTH, 3, tracked stages after decode. Stage 0 = E, stage DEPTH-1 = W. Legal range 2..8.
- SRCS, 2, source operands per instruction.
- PC_REG, 15, register index never forwarded or hazarded (reads PC+8).
- SW, $clog2(DEPTH), forward-select width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- hold  in  1  global freeze (memory wait); no state changes
- flush_e  in  1  branch taken; the instruction entering E becomes a bubble
- issue_valid  in  1  decode holds a real instruction
- issue_we  in  1  decode instruction writes a register
- issue_wa  in  AW  decode destination register
- issue_isload  in  1  decode destination is loaded from memory
- ra_d  in  SRCS*AW  decode source registers; source i is in bits [i*AW +: AW]
- ra_used_d  in  SRCS  source i is actually read
- stall_d  out  1  load-use hazard: hold F and D, insert a bubble into E
- fwd_sel_e  out  SRCS*SW  per-source select for the E-stage operand: 0 = regfile value, k = result of stage k (1..DEPTH-1)
- busy_e  out  1  the stage-0 entry is valid (debug/visibility)

Behaviour:
- State: DEPTH entries {v, we, wa, ld} plus the fwd_sel_e register. Reset clears every v and sets fwd_sel_e=0. Reset wins over all other inputs. stall_d=0 and busy_e=0 after reset.
- Shift, when hold=0:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= decode fields if issue_valid & ~stall_d & ~flush_e; otherwise entry[0].v <= 0.
- hold=1: all entries and fwd_sel_e keep their values. stall_d is still evaluated combinationally.
- Match(i, k): ra_used_d[i] & ra_d[i]≠PC_REG & entry[k].v & entry[k].we & entry[k].wa == ra_d[i].
- stall_d, combinational:
  - Asserted if issue_valid and Match(i, k) with entry[k].ld=1 for any i and any k with k+1 < DEPTH-1. This means the load data will not yet be at W when the consumer reaches E.
  - For DEPTH=3 this reduces to a load currently in E.
  - Forced to 0 while reset=1.
- Forward select, registered when hold=0:
  - fwd_sel_e[i] <= k+1 for the smallest k in 0..DEPTH-2 with Match(i, k). The youngest producer wins.
  - fwd_sel_e[i] <= 0 if no such k exists, or if the stall/flush bubble is inserted.
- Stage DEPTH-1 is not matched at decode; the regfile writes first and reads second, so the regfile value is already correct.
- Simultaneous stall_d and flush_e: the bubble is inserted once; stall_d is overridden by the flush for the next cycle (the decode instruction is being squashed).
- Simultaneous hold and flush_e: hold wins, and the flush is not consumed.
- Writes to PC_REG: tracked in entries, but never matched.
- Latency: fwd_sel_e is valid exactly one cycle after the consumer leaves decode.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (32-bit): counts cycles with stall_d & ~hold, saturating at 0xFFFF_FFFF.
  - fwd_cnt (32-bit): counts registered nonzero selects summed over sources per cycle, saturating.
  - Both clear on reset.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Back-to-back ALU dependency, DEPTH=3: issue ADD R1 then SUB R2,R1,R3 → stall_d=0; fwd_sel_e[0]=1 next cycle (from M), fwd_sel_e[1]=0.
- One-gap dependency: ADD R4; NOP; ORR R5,R4,R4 → fwd_sel_e[0]=fwd_sel_e[1]=2 (from W).
- Load-use: LDR R6 then ADD R7,R6,R0 → stall_d=1 for exactly 1 cycle, a bubble in E (busy_e=0), then fwd_sel_e[0]=2.
- Youngest wins: ADD R1; ADD R1; USE R1 → fwd_sel_e=1, not 2. Source R15 with a pending write to R15 → fwd_sel_e=0, stall_d=0.
- flush_e asserted with a load in D → the entry is invalidated; the next instruction reading its destination sees stall_d=0 and fwd_sel_e=0.
- hold=1 for 3 cycles mid-sequence → entries and fwd_sel_e are frozen; resuming gives the same selects as an unheld run. Reset mid-stream → all selects 0, stall_d=0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Decode-side handshake bundle for fwd_scoreboard: decode fields in,
// stall and forward selects out.
interface fwd_scoreboard_if #(
    parameter int AW   = 4,
    parameter int SRCS = 2,
    parameter int SW   = 2
);
    logic                 hold;
    logic                 flush_e;
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_wa;
    logic                 issue_isload;
    logic [SRCS*AW-1:0]   ra_d;
    logic [SRCS-1:0]      ra_used_d;
    logic                 stall_d;
    logic [SRCS*SW-1:0]   fwd_sel_e;
    logic                 busy_e;

    modport master (
        output hold, flush_e, issue_valid, issue_we,
        output issue_wa, issue_isload, ra_d, ra_used_d,
        input  stall_d, fwd_sel_e, busy_e
    );

    modport slave (
        input  hold, flush_e, issue_valid, issue_we,
        input  issue_wa, issue_isload, ra_d, ra_used_d,
        output stall_d, fwd_sel_e, busy_e
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard tracking DEPTH post-decode destination tags.
// Define FWD_SCOREBOARD_STATS_EN to add stall_cnt / fwd_cnt counters.
module fwd_scoreboard #(
    parameter int NREG   = 16,
    parameter int DEPTH  = 3,
    parameter int SRCS   = 2,
    parameter int PC_REG = 15
) (
    input  logic            clk,
    input  logic            reset,
    fwd_scoreboard_if.slave sb
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     fwd_cnt
`endif
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(DEPTH);

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] wa;
        logic          ld;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [SRCS*SW-1:0] fwd_q;
    logic [SRCS*SW-1:0] fwd_d;
    logic [DEPTH-2:0]   match [SRCS];
    logic               stall;
    logic               ins;

    // W (stage DEPTH-1) is never matched: the regfile write-then-read covers it
    always_comb begin
        for (int i = 0; i < SRCS; i++) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                match[i][k] = sb.ra_used_d[i]
                    && (sb.ra_d[i*AW +: AW] != AW'(PC_REG))
                    && ent_q[k].v && ent_q[k].we
                    && (ent_q[k].wa == sb.ra_d[i*AW +: AW]);
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < SRCS; i++) begin
            for (int k = 0; k + 2 < DEPTH; k++) begin
                if (match[i][k] && ent_q[k].ld) begin
                    stall = 1'b1;
                end
            end
        end
        stall = stall && sb.issue_valid && !reset;
    end

    assign ins = sb.issue_valid && !stall && !sb.flush_e;

    // descending scan so the youngest producer overwrites older ones
    always_comb begin
        fwd_d = fwd_q;
        if (!sb.hold) begin
            fwd_d = '0;
            for (int i = 0; i < SRCS; i++) begin
                for (int k = DEPTH - 2; k >= 0; k--) begin
                    if (ins && match[i][k]) begin
                        fwd_d[i*SW +: SW] = SW'(k + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k];
        end
        if (!sb.hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_d[k] = ent_q[k-1];
            end
            ent_d[0].v  = ins;
            ent_d[0].we = sb.issue_we;
            ent_d[0].wa = sb.issue_wa;
            ent_d[0].ld = sb.issue_isload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            fwd_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            fwd_q <= fwd_d;
        end
    end

    assign sb.stall_d   = stall;
    assign sb.fwd_sel_e = fwd_q;
    assign sb.busy_e    = ent_q[0].v;

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;
    logic [32:0] fwd_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !sb.hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        fwd_sum = {1'b0, fwd_cnt_q};
        if (!sb.hold) begin
            for (int i = 0; i < SRCS; i++) begin
                if (fwd_d[i*SW +: SW] != '0) begin
                    fwd_sum = fwd_sum + 33'd1;
                end
            end
        end
        fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table plus randomized run
// against a tag-list reference model.
module tb_fwd_scoreboard;
    localparam int DEPTH  = 3;
    localparam int SRCS   = 2;
    localparam int AW     = 4;
    localparam int SW     = 2;
    localparam int PC_REG = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.AW(AW), .SRCS(SRCS), .SW(SW)) sb ();

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    fwd_scoreboard #(
        .NREG(16), .DEPTH(DEPTH), .SRCS(SRCS), .PC_REG(PC_REG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sb(sb)
`ifdef FWD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt(fwd_cnt)
`endif
    );

    typedef struct {
        bit rst, hold, flush, valid, we, ld;
        int wa, ra0, ra1;
        bit [1:0] used;
        bit e_stall, e_busy;
        int e_f0, e_f1;
    } vec_t;

    typedef struct {
        bit v, we, ld;
        int wa;
    } ment_t;

    vec_t  tbl[$];
    ment_t m_e [DEPTH];
    int    m_fwd [SRCS];

    bit i_rst, i_hold, i_flush, i_valid, i_we, i_ld;
    int i_wa, i_ra0, i_ra1;
    bit [1:0] i_used;

    int checks = 0;
    int failures = 0;

    task automatic add(input bit rst, hold, flush, valid, we, ld,
                       input int wa, ra0, ra1, input bit [1:0] used,
                       input bit st, bz, input int f0, f1);
        vec_t t;
        t.rst = rst; t.hold = hold; t.flush = flush;
        t.valid = valid; t.we = we; t.ld = ld;
        t.wa = wa; t.ra0 = ra0; t.ra1 = ra1; t.used = used;
        t.e_stall = st; t.e_busy = bz; t.e_f0 = f0; t.e_f1 = f1;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic apply();
        reset           = i_rst;
        sb.hold         = i_hold;
        sb.flush_e      = i_flush;
        sb.issue_valid  = i_valid;
        sb.issue_we     = i_we;
        sb.issue_wa     = AW'(i_wa);
        sb.issue_isload = i_ld;
        sb.ra_d         = {AW'(i_ra1), AW'(i_ra0)};
        sb.ra_used_d    = i_used;
    endtask

    function automatic bit m_match(int i, int k);
        int r;
        r = (i == 0) ? i_ra0 : i_ra1;
        return i_used[i] && (r != PC_REG) && m_e[k].v
            && m_e[k].we && (m_e[k].wa == r);
    endfunction

    // a load still needs to reach W before its consumer can enter E
    function automatic bit m_stall();
        bit s = 0;
        for (int i = 0; i < SRCS; i++)
            for (int k = 0; k < DEPTH; k++)
                if (k + 1 < DEPTH - 1 && m_match(i, k) && m_e[k].ld)
                    s = 1;
        return s && i_valid && !i_rst;
    endfunction

    task automatic m_step();
        bit ins;
        int f [SRCS];
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) m_e[k] = '{0, 0, 0, 0};
            for (int i = 0; i < SRCS; i++) m_fwd[i] = 0;
        end else if (!i_hold) begin
            ins = i_valid && !m_stall() && !i_flush;
            for (int i = 0; i < SRCS; i++) begin
                f[i] = 0;
                if (ins) begin
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        if (m_match(i, k)) begin
                            f[i] = k + 1;
                            break;
                        end
                    end
                end
            end
            for (int k = DEPTH - 1; k > 0; k--) m_e[k] = m_e[k-1];
            m_e[0].v  = ins;
            m_e[0].we = i_we;
            m_e[0].wa = i_wa;
            m_e[0].ld = i_ld;
            for (int i = 0; i < SRCS; i++) m_fwd[i] = f[i];
        end
    endtask

    function automatic int rreg();
        int x = $urandom_range(0, 7);
        return (x == 7) ? PC_REG : x;
    endfunction

    initial begin
        for (int k = 0; k < DEPTH; k++) m_e[k] = '{0, 0, 0, 0};
        for (int i = 0; i < SRCS; i++) m_fwd[i] = 0;

        // rst hold flsh vld we ld wa ra0 ra1 used | stall busy f0 f1
        add(0,0,0,1,1,0, 1, 2, 3,2'b11, 0,0,0,0);
        add(0,0,0,1,1,0, 2, 1, 3,2'b11, 0,1,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,1,0);
        add(0,0,0,1,1,0, 4, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,0,0);
        add(0,0,0,1,1,0, 5, 4, 4,2'b11, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,2,2);
        add(0,0,0,1,1,1, 6, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,1,1,0, 7, 6, 0,2'b11, 1,1,0,0);
        add(0,0,0,1,1,0, 7, 6, 0,2'b11, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,2,0);
        add(0,0,0,1,1,0, 1, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,1,1,0, 1, 0, 0,2'b00, 0,1,0,0);
        add(0,0,0,1,0,0, 0, 1, 1,2'b11, 0,1,0,0);
        add(0,0,0,1,1,0,15, 0, 0,2'b00, 0,1,1,1);
        add(0,0,0,1,0,0, 0,15,15,2'b11, 0,1,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,0,0);
        add(0,0,0,1,1,1,15, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,1,0,0, 0,15,15,2'b11, 0,1,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,0,0);
        add(0,0,1,1,1,1, 8, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,1,1,0, 9, 8, 8,2'b11, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,0,0);
        add(0,0,0,1,1,1,10, 0, 0,2'b00, 0,0,0,0);
        add(0,0,1,1,0,0, 0,10,10,2'b11, 1,1,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,0,0,0);
        add(0,0,0,1,1,0,11, 0, 0,2'b00, 0,0,0,0);
        add(0,1,1,1,0,0, 0,11, 0,2'b01, 0,1,0,0);
        add(0,0,0,1,0,0, 0,11, 0,2'b01, 0,1,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,1,0);
        add(0,0,0,1,1,1,12, 0, 0,2'b00, 0,0,0,0);
        add(0,1,0,1,0,0, 0,12, 0,2'b01, 1,1,0,0);
        add(0,1,0,1,0,0, 0,12, 0,2'b01, 1,1,0,0);
        add(0,1,0,1,0,0, 0,12, 0,2'b01, 1,1,0,0);
        add(0,0,0,1,0,0, 0,12, 0,2'b01, 1,1,0,0);
        add(0,0,0,1,0,0, 0,12, 0,2'b01, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,2,0);
        add(0,0,0,1,1,1,13, 0, 0,2'b00, 0,0,0,0);
        add(1,0,0,1,0,0, 0,13,13,2'b11, 0,1,0,0);
        add(0,0,0,1,0,0, 0,13,13,2'b11, 0,0,0,0);
        add(0,0,0,0,0,0, 0, 0, 0,2'b00, 0,1,0,0);

        i_rst = 1; i_hold = 0; i_flush = 0; i_valid = 0;
        i_we = 0; i_ld = 0; i_wa = 0; i_ra0 = 0; i_ra1 = 0; i_used = 0;
        apply();
        repeat (2) @(posedge clk);
        m_step();
        #1;
        i_rst = 0;
        apply();
        @(negedge clk);
        chk("reset.stall", sb.stall_d, 0);
        chk("reset.busy", sb.busy_e, 0);
        chk("reset.fwd", sb.fwd_sel_e, 0);
        m_step();
        @(posedge clk);
        #1;

        for (int n = 0; n < tbl.size(); n++) begin
            i_rst = tbl[n].rst; i_hold = tbl[n].hold;
            i_flush = tbl[n].flush; i_valid = tbl[n].valid;
            i_we = tbl[n].we; i_ld = tbl[n].ld; i_wa = tbl[n].wa;
            i_ra0 = tbl[n].ra0; i_ra1 = tbl[n].ra1; i_used = tbl[n].used;
            apply();
            @(negedge clk);
            chk($sformatf("vec%0d.stall", n), sb.stall_d, tbl[n].e_stall);
            chk($sformatf("vec%0d.busy", n), sb.busy_e, tbl[n].e_busy);
            chk($sformatf("vec%0d.fwd0", n), sb.fwd_sel_e[0 +: SW], tbl[n].e_f0);
            chk($sformatf("vec%0d.fwd1", n), sb.fwd_sel_e[SW +: SW], tbl[n].e_f1);
            m_step();
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 3000; n++) begin
            i_rst   = (n < 2) || ($urandom_range(0, 49) == 0);
            i_hold  = ($urandom_range(0, 99) < 15);
            i_flush = ($urandom_range(0, 99) < 10);
            i_valid = ($urandom_range(0, 99) < 75);
            i_we    = ($urandom_range(0, 99) < 80);
            i_ld    = ($urandom_range(0, 99) < 30);
            i_wa    = rreg();
            i_ra0   = rreg();
            i_ra1   = rreg();
            i_used  = i_valid ? 2'($urandom_range(0, 3)) : 2'b00;
            apply();
            @(negedge clk);
            chk($sformatf("rnd%0d.stall", n), sb.stall_d, m_stall());
            chk($sformatf("rnd%0d.busy", n), sb.busy_e, m_e[0].v);
            chk($sformatf("rnd%0d.fwd0", n), sb.fwd_sel_e[0 +: SW], m_fwd[0]);
            chk($sformatf("rnd%0d.fwd1", n), sb.fwd_sel_e[SW +: SW], m_fwd[1]);
            m_step();
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
